// File: rtl/engagement_sequencer.sv
// engagement_sequencer
// Confirm / arm / fire / cooldown sequencer that sits downstream of combat
// management. It produces a one-cycle fire strobe and keeps a munition count.
// An emergency landing alert forces ABORT from every state. All outputs are
// registers loaded from the next-state decode, so no input reaches an output
// combinationally.
`timescale 1ns/1ps

module engagement_sequencer #(
  parameter int unsigned LOCK_CONFIRM    = 4,
  parameter int unsigned ARM_CYCLES      = 8,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned MAX_ROUNDS      = 4,
  parameter logic [31:0] MIN_DISTANCE    = 32'd500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        threat_detected,
  input  logic        safe_to_engage,
  input  logic [31:0] distance_to_target,
  input  logic        emergency_landing_alert,
  input  logic        reload,
  output logic        missile_fire,
  output logic        lock_acquired,
  output logic        abort_flag,
  output logic [3:0]  rounds_remaining,
  output logic [2:0]  engagement_state
);

  // One shared counter serves ACQUIRE, ARMING and COOLDOWN. It only ever
  // counts up to (longest phase - 1).
  localparam int unsigned CNT_MAX_AB =
    (LOCK_CONFIRM > ARM_CYCLES) ? LOCK_CONFIRM : ARM_CYCLES;
  localparam int unsigned CNT_MAX =
    (CNT_MAX_AB > COOLDOWN_CYCLES) ? CNT_MAX_AB : COOLDOWN_CYCLES;
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CONFIRM - 1);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]       ROUNDS_FULL = 4'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_ARMING   = 3'd2,
    ST_FIRE     = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_ABORT    = 3'd5
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       rounds_reg;
  logic [3:0]       rounds_next;
  logic             fire_reg;
  logic             lock_reg;
  logic             abort_reg;
  logic [2:0]       state_code_reg;
  logic             engage_ok;
  logic             reload_ok;

  // Engagement qualification; an empty magazine blocks any new engagement.
  always_comb begin
    engage_ok = threat_detected && safe_to_engage &&
                (distance_to_target >= MIN_DISTANCE) &&
                (rounds_reg != 4'd0);
    reload_ok = reload && ((state_reg == ST_IDLE) || (state_reg == ST_ABORT));
  end

  // Next-state, counter and munition-count decisions.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rounds_next = rounds_reg;

    // Reload depends only on the current state, so it is honoured in ABORT
    // even while the emergency flag keeps the sequencer parked there.
    if (reload_ok) begin
      rounds_next = ROUNDS_FULL;
    end

    if (emergency_landing_alert) begin
      state_next = ST_ABORT;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (engage_ok) begin
            state_next = ST_ACQUIRE;
            cnt_next   = '0;
          end
        end
        ST_ACQUIRE: begin
          if (!engage_ok) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == LOCK_LAST) begin
            state_next = ST_ARMING;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_ARMING: begin
          if (!engage_ok) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == ARM_LAST) begin
            // The round is spent as the sequencer commits to FIRE.
            state_next  = ST_FIRE;
            cnt_next    = '0;
            rounds_next = rounds_reg - 4'd1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_FIRE: begin
          state_next = ST_COOLDOWN;
          cnt_next   = '0;
        end
        ST_COOLDOWN: begin
          // Qualification is ignored here; a new shot starts from IDLE.
          if (cnt_reg == COOL_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_ABORT: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
        default: begin
          // Unused encodings fall back to IDLE.
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter, munitions and Moore output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      rounds_reg     <= ROUNDS_FULL;
      fire_reg       <= 1'b0;
      lock_reg       <= 1'b0;
      abort_reg      <= 1'b0;
      state_code_reg <= 3'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rounds_reg     <= rounds_next;
      fire_reg       <= (state_next == ST_FIRE);
      lock_reg       <= (state_next == ST_ARMING) || (state_next == ST_FIRE);
      abort_reg      <= (state_next == ST_ABORT);
      state_code_reg <= state_next;
    end
  end

  assign missile_fire     = fire_reg;
  assign lock_acquired    = lock_reg;
  assign abort_flag       = abort_reg;
  assign rounds_remaining = rounds_reg;
  assign engagement_state = state_code_reg;

endmodule

// File: tb/tb_engagement_sequencer.sv
// Scoreboard bench for engagement_sequencer. The stimulus pushes the expected
// state and round count for specific future clock edges, and a monitor on the
// falling edge compares every expectation that is due.
`timescale 1ns/1ps

module tb_engagement_sequencer;

  logic        CLK;
  logic        RST;
  logic        threat_detected;
  logic        safe_to_engage;
  logic [31:0] distance_to_target;
  logic        emergency_landing_alert;
  logic        reload;
  logic        missile_fire;
  logic        lock_acquired;
  logic        abort_flag;
  logic [3:0]  rounds_remaining;
  logic [2:0]  engagement_state;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int e0 = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic [3:0] rnd;
  } exp_t;

  exp_t sb[$];

  engagement_sequencer dut (
    .CLK(CLK),
    .RST(RST),
    .threat_detected(threat_detected),
    .safe_to_engage(safe_to_engage),
    .distance_to_target(distance_to_target),
    .emergency_landing_alert(emergency_landing_alert),
    .reload(reload),
    .missile_fire(missile_fire),
    .lock_acquired(lock_acquired),
    .abort_flag(abort_flag),
    .rounds_remaining(rounds_remaining),
    .engagement_state(engagement_state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic check_outs(input string nm, input logic [2:0] st, input logic [3:0] rnd);
    logic fe, le, ae;
    fe = (st == 3'd3);
    le = (st == 3'd2) || (st == 3'd3);
    ae = (st == 3'd5);
    checks++;
    if ({engagement_state, rounds_remaining, missile_fire, lock_acquired, abort_flag} !==
        {st, rnd, fe, le, ae}) begin
      errors++;
      $display("FAIL %s: got state=%0d rounds=%0d fire=%b lock=%b abort=%b, want state=%0d rounds=%0d fire=%b lock=%b abort=%b",
               nm, engagement_state, rounds_remaining, missile_fire, lock_acquired, abort_flag,
               st, rnd, fe, le, ae);
    end else begin
      $display("ok   %s @edge %0d: state=%0d rounds=%0d", nm, edge_n, engagement_state, rounds_remaining);
    end
  endtask

  // Monitor: compare every expectation that falls due at this edge.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_n) begin
        check_outs(sb[i].name, sb[i].st, sb[i].rnd);
        sb.delete(i);
      end else if (sb[i].cyc < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d never sampled (now %0d)", sb[i].name, sb[i].cyc, edge_n);
        sb.delete(i);
      end
    end
  end

  task automatic mark();
    e0 = edge_n + 1;
  endtask

  task automatic expect_at(input int rel, input string nm, input logic [2:0] st, input logic [3:0] rnd);
    exp_t e;
    e.cyc  = e0 + rel;
    e.name = nm;
    e.st   = st;
    e.rnd  = rnd;
    sb.push_back(e);
  endtask

  task automatic adv_to(input int rel);
    while (edge_n < e0 + rel) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic full_shot(input logic [3:0] b, input bit do_reload, input string tag);
    threat_detected    = 1'b1;
    safe_to_engage     = 1'b1;
    distance_to_target = 32'd1000;
    mark();
    expect_at(0,  {tag, "_acq"},       3'd1, b);
    expect_at(4,  {tag, "_arm"},       3'd2, b);
    expect_at(11, {tag, "_arm_last"},  3'd2, b);
    expect_at(12, {tag, "_fire"},      3'd3, b - 4'd1);
    expect_at(13, {tag, "_cool"},      3'd4, b - 4'd1);
    expect_at(14, {tag, "_cool_rld"},  3'd4, b - 4'd1);
    expect_at(28, {tag, "_cool_last"}, 3'd4, b - 4'd1);
    expect_at(29, {tag, "_idle"},      3'd0, b - 4'd1);
    adv_to(13);
    threat_detected = 1'b0;
    if (do_reload) reload = 1'b1;
    adv_to(14);
    reload = 1'b0;
    adv_to(29);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST                     = 1'b0;
    threat_detected         = 1'b0;
    safe_to_engage          = 1'b0;
    distance_to_target      = 32'd0;
    emergency_landing_alert = 1'b0;
    reload                  = 1'b0;
    #1 RST = 1'b1;
    #1 check_outs("reset_init", 3'd0, 4'd4);
    #10 RST = 1'b0;
    @(posedge CLK); #1;

    // Nominal shot with defaults; re-acquire at the earliest edge E0+30.
    threat_detected    = 1'b1;
    safe_to_engage     = 1'b1;
    distance_to_target = 32'd1000;
    mark();
    expect_at(0,  "nom_acq",        3'd1, 4'd4);
    expect_at(3,  "nom_acq_last",   3'd1, 4'd4);
    expect_at(4,  "nom_arm",        3'd2, 4'd4);
    expect_at(11, "nom_arm_last",   3'd2, 4'd4);
    expect_at(12, "nom_fire",       3'd3, 4'd3);
    expect_at(13, "nom_cool",       3'd4, 4'd3);
    expect_at(28, "nom_cool_last",  3'd4, 4'd3);
    expect_at(29, "nom_idle",       3'd0, 4'd3);
    expect_at(30, "nom_reacq",      3'd1, 4'd3);
    expect_at(31, "nom_drop_idle",  3'd0, 4'd3);
    adv_to(30);
    threat_detected = 1'b0;
    adv_to(31);

    // Asynchronous reset in the middle of ARMING with three rounds left.
    threat_detected = 1'b1;
    mark();
    expect_at(4, "rst_pre_arm", 3'd2, 4'd3);
    adv_to(6);
    #2 RST = 1'b1;
    #1 check_outs("rst_async", 3'd0, 4'd4);
    threat_detected = 1'b0;
    @(posedge CLK); #3;
    RST = 1'b0;
    @(posedge CLK); #1;

    // One-cycle safe_to_engage drop in ARMING restarts confirmation.
    threat_detected    = 1'b1;
    safe_to_engage     = 1'b1;
    distance_to_target = 32'd1000;
    mark();
    expect_at(4,  "gap_arm",       3'd2, 4'd4);
    expect_at(6,  "gap_idle",      3'd0, 4'd4);
    expect_at(7,  "gap_reacq",     3'd1, 4'd4);
    expect_at(10, "gap_acq_last",  3'd1, 4'd4);
    expect_at(11, "gap_arm2",      3'd2, 4'd4);
    expect_at(12, "gap_nofire",    3'd2, 4'd4);
    expect_at(18, "gap_arm_last",  3'd2, 4'd4);
    expect_at(19, "gap_fire",      3'd3, 4'd3);
    expect_at(20, "gap_cool",      3'd4, 4'd3);
    expect_at(35, "gap_cool_last", 3'd4, 4'd3);
    expect_at(36, "gap_idle2",     3'd0, 4'd3);
    expect_at(37, "gap_idle3",     3'd0, 4'd3);
    adv_to(5);
    safe_to_engage = 1'b0;
    adv_to(6);
    safe_to_engage = 1'b1;
    adv_to(20);
    threat_detected = 1'b0;
    adv_to(37);

    // Distance boundary: 499 stays idle, 500 engages.
    threat_detected    = 1'b1;
    distance_to_target = 32'd499;
    mark();
    expect_at(0, "dist499_idle",  3'd0, 4'd3);
    expect_at(5, "dist499_idle2", 3'd0, 4'd3);
    adv_to(5);
    distance_to_target = 32'd500;
    mark();
    // Emergency raised during FIRE: round stays spent, ABORT holds, then IDLE.
    expect_at(0,  "dist500_acq",  3'd1, 4'd3);
    expect_at(4,  "dist500_arm",  3'd2, 4'd3);
    expect_at(12, "emf_fire",     3'd3, 4'd2);
    expect_at(13, "emf_abort",    3'd5, 4'd2);
    expect_at(14, "emf_abort2",   3'd5, 4'd2);
    expect_at(15, "emf_idle",     3'd0, 4'd2);
    adv_to(12);
    emergency_landing_alert = 1'b1;
    threat_detected         = 1'b0;
    adv_to(14);
    emergency_landing_alert = 1'b0;
    adv_to(15);

    // Depletion: reload during COOLDOWN of the last shot is ignored.
    full_shot(4'd2, 1'b0, "shot_a");
    full_shot(4'd1, 1'b1, "shot_b");

    // Empty magazine parks in IDLE despite full qualification.
    threat_detected    = 1'b1;
    safe_to_engage     = 1'b1;
    distance_to_target = 32'd1000;
    mark();
    expect_at(0,  "empty_idle",  3'd0, 4'd0);
    expect_at(10, "empty_idle2", 3'd0, 4'd0);
    adv_to(10);

    // Reload in IDLE refills, then the next shot proceeds.
    reload = 1'b1;
    mark();
    expect_at(0, "reload_idle", 3'd0, 4'd4);
    adv_to(0);
    reload = 1'b0;
    full_shot(4'd4, 1'b0, "post_reload");

    // Emergency from IDLE.
    emergency_landing_alert = 1'b1;
    mark();
    expect_at(0, "emi_abort", 3'd5, 4'd3);
    expect_at(1, "emi_idle",  3'd0, 4'd3);
    adv_to(0);
    emergency_landing_alert = 1'b0;
    adv_to(1);

    // Emergency from ACQUIRE; reload while in ABORT restores rounds.
    threat_detected = 1'b1;
    mark();
    expect_at(0, "ema_acq",        3'd1, 4'd3);
    expect_at(1, "ema_acq2",       3'd1, 4'd3);
    expect_at(2, "ema_abort",      3'd5, 4'd3);
    expect_at(3, "ema_abort_rld",  3'd5, 4'd4);
    expect_at(4, "ema_idle",       3'd0, 4'd4);
    adv_to(1);
    emergency_landing_alert = 1'b1;
    threat_detected         = 1'b0;
    adv_to(2);
    reload = 1'b1;
    adv_to(3);
    reload                  = 1'b0;
    emergency_landing_alert = 1'b0;
    adv_to(4);

    @(posedge CLK); #1;
    @(negedge CLK); #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
